// File: rtl/nibble_pkg.sv
// Shared types and default widths for the nibble accumulator slice.
package nibble_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StDone  = 2'd2
  } state_e;

  localparam int unsigned DefDataW = 4;
  localparam int unsigned DefAccW  = 6;

endpackage

// File: rtl/nibble_add_ext.sv
// Combinational accumulator + zero-extended operand + carry-in, ACC_W sum with carry-out.
module nibble_add_ext
  import nibble_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW
) (
  input  logic [ACC_W-1:0]  a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              cout_o
);

  logic [ACC_W:0] full;

  always_comb begin
    full   = {1'b0, a_i} + (ACC_W + 1)'(b_i) + (ACC_W + 1)'(cin_i);
    sum_o  = full[ACC_W-1:0];
    cout_o = full[ACC_W];
  end

endmodule

// File: rtl/nibble_accumulator.sv
// Sums a frame of COUNT operands (each with carry-in) and hands off the total with a
// sticky overflow flag over a valid/ready output handshake.
module nibble_accumulator
  import nibble_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned COUNT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              out_ovf,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(COUNT + 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W-1:0] add_sum;
  logic             add_cout;
  logic [CntW-1:0]  cnt_inc;
  logic             accept;

  nibble_add_ext #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .a_i    (acc_q),
    .b_i    (in_data),
    .cin_i  (in_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_ready  = (state_q != StDone);
    out_valid = (state_q == StDone);
    busy      = (state_q != StIdle);
    accept    = in_valid && in_ready;
    cnt_inc   = cnt_q + CntW'(1);

    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) begin
          acc_d   = add_sum;
          ovf_d   = ovf_q | add_cout;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CntW'(COUNT)) ? StDone : StAccum;
        end
      end
      StDone: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = StIdle;
      end
    endcase

    // Totals are masked outside the handshake so idle consumers see zeros.
    out_sum = out_valid ? acc_q : '0;
    out_ovf = out_valid ? ovf_q : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nibble_accumulator.sv
// Directed self-checking bench for nibble_accumulator with hand-computed frame totals.
module tb_nibble_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_cin;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int total;
  int bad;

  nibble_accumulator #(
    .DATA_W (4),
    .ACC_W  (6),
    .COUNT  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one operand for a single edge; in_ready is known high at each call site.
  task automatic push(input logic [3:0] d, input logic c);
    in_valid = 1'b1;
    in_data  = d;
    in_cin   = c;
    tick();
    in_valid = 1'b0;
    in_data  = 4'hx;
    in_cin   = 1'bx;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    #2;
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Basic frame: 7 + 4+1 + 0 + 8+1 = 21
    push(4'd7, 1'b0);
    check("basic_busy_after_first", 32'(busy), 32'd1);
    push(4'd4, 1'b1);
    push(4'd0, 1'b0);
    check("basic_not_done_early", 32'(out_valid), 32'd0);
    push(4'd8, 1'b1);
    check("basic_out_valid", 32'(out_valid), 32'd1);
    check("basic_out_sum", 32'(out_sum), 32'd21);
    check("basic_out_ovf", 32'(out_ovf), 32'd0);
    check("basic_in_ready_done", 32'(in_ready), 32'd0);
    tick();
    check("basic_drained_valid", 32'(out_valid), 32'd0);
    check("basic_drained_busy", 32'(busy), 32'd0);
    check("basic_drained_in_ready", 32'(in_ready), 32'd1);
    check("basic_drained_sum", 32'(out_sum), 32'd0);

    // Overflow: 4 x (15+1) = 64 wraps to 0
    for (int i = 0; i < 4; i++) push(4'd15, 1'b1);
    check("ovf_out_valid", 32'(out_valid), 32'd1);
    check("ovf_out_sum", 32'(out_sum), 32'd0);
    check("ovf_out_ovf", 32'(out_ovf), 32'd1);
    tick();

    // Backpressure: 1+2+3+4 = 10 held while out_ready low, extra operands refused
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) push(4'(i), 1'b0);
    in_valid = 1'b1;
    in_data  = 4'd5;
    in_cin   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'd10);
      check("bp_out_ovf", 32'(out_ovf), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    check("bp_out_sum_end", 32'(out_sum), 32'd10);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_drained_valid", 32'(out_valid), 32'd0);
    tick();
    check("bp_single_drain", 32'(out_valid), 32'd0);
    check("bp_idle_busy", 32'(busy), 32'd0);

    // Gapped input: 2,2,2,2 with three idle cycles between accepts
    for (int i = 0; i < 4; i++) begin
      push(4'd2, 1'b0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          in_data = 4'd15;
          in_cin  = 1'b1;
          tick();
          check("gap_no_valid", 32'(out_valid), 32'd0);
          check("gap_busy", 32'(busy), 32'd1);
        end
      end
    end
    check("gap_out_valid", 32'(out_valid), 32'd1);
    check("gap_out_sum", 32'(out_sum), 32'd8);
    tick();

    // Reset mid-frame discards 9+9
    push(4'd9, 1'b0);
    push(4'd9, 1'b0);
    do_reset();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) push(4'd1, 1'b0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_sum", 32'(out_sum), 32'd4);
    check("post_rst_ovf", 32'(out_ovf), 32'd0);
    tick();

    // Back-to-back: overflowing frame, then 3,3,3,3 (cin1) offered continuously
    in_valid = 1'b1;
    in_data  = 4'd15;
    in_cin   = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    check("b2b_first_ovf", 32'(out_ovf), 32'd1);
    in_data = 4'd3;
    in_cin  = 1'b1;
    tick();
    check("b2b_drain_valid", 32'(out_valid), 32'd0);
    check("b2b_drain_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("b2b_three_accepts", 32'(out_valid), 32'd0);
    tick();
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    check("b2b_second_sum", 32'(out_sum), 32'd16);
    check("b2b_second_ovf", 32'(out_ovf), 32'd0);
    in_valid = 1'b0;
    tick();
    check("b2b_final_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
